// File: rtl/pc_tx_arbiter_if.sv
// Bundle of requester handshakes and the PC_TX FIFO write port seen by pc_tx_arbiter.
// master is the arbiter side, slave is the requesters/FIFO side.
interface pc_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    i_req;
    logic [NUM_REQ-1:0]    i_last;
    logic [32*NUM_REQ-1:0] i_data;
    logic [NUM_REQ-1:0]    o_ack;
    logic [31:0]           o_fifo_write_word_data;
    logic                  o_fifo_write_word_cmd;
    logic                  i_fifo_full;
    logic [2:0]            o_grant_id;
    logic                  o_busy;
    logic                  o_timeout;

    modport master (
        input  i_req, i_last, i_data, i_fifo_full,
        output o_ack, o_fifo_write_word_data, o_fifo_write_word_cmd,
        output o_grant_id, o_busy, o_timeout
    );

    modport slave (
        output i_req, i_last, i_data, i_fifo_full,
        input  o_ack, o_fifo_write_word_data, o_fifo_write_word_cmd,
        input  o_grant_id, o_busy, o_timeout
    );
endinterface

// File: rtl/pc_tx_arbiter.sv
// Message-granular round-robin arbiter in front of the PC_TX word FIFO write port.
// Optional header word per grant when ARB_HEADER_EN is defined.
module pc_tx_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    pc_tx_arbiter_if.master      bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
`ifdef ARB_HEADER_EN
        , ST_HDR = 2'd2
`endif
    } state_t;

    state_t      state_r;
    logic [2:0]  rr_ptr_r;
    logic [2:0]  grant_id_r;
    logic [7:0]  word_cnt_r;
    logic [15:0] stall_cnt_r;
    logic        busy_r;
    logic        timeout_r;

    logic [7:0]  req_ext_s;
    logic [7:0]  last_ext_s;
    logic [31:0] data_arr_s [8];
    logic [3:0]  cand_s;
    logic [2:0]  sel_id_s;
    logic        any_req_s;
    logic        req_g_s;
    logic        last_g_s;
    logic [31:0] data_g_s;
    logic        accept_s;
    logic        hdr_wr_s;
    logic [NUM_REQ-1:0] ack_s;

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        if (idx == 3'(NUM_REQ - 1)) begin
            return 3'd0;
        end else begin
            return idx + 3'd1;
        end
    endfunction

    // Widen requester vectors to 8 entries so a 3-bit id indexes them directly.
    always_comb begin
        req_ext_s  = 8'd0;
        last_ext_s = 8'd0;
        req_ext_s[NUM_REQ-1:0]  = bus.i_req;
        last_ext_s[NUM_REQ-1:0] = bus.i_last;
        for (int k = 0; k < 8; k++) begin
            data_arr_s[k] = 32'd0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            data_arr_s[k] = bus.i_data[32*k +: 32];
        end
    end

    // Round-robin pick: scan downward so the nearest requester at/after rr_ptr_r wins.
    always_comb begin
        sel_id_s  = 3'd0;
        any_req_s = 1'b0;
        cand_s    = 4'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s = {1'b0, rr_ptr_r} + 4'(i);
            if (cand_s >= 4'(NUM_REQ)) begin
                cand_s = cand_s - 4'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (req_ext_s[cand_s[2:0]]) begin
                sel_id_s  = cand_s[2:0];
                any_req_s = 1'b1;
            end else begin
                sel_id_s  = sel_id_s;
                any_req_s = any_req_s;
            end
        end
    end

    // Granted requester's view and the zero-latency FIFO write path.
    always_comb begin
        req_g_s  = req_ext_s[grant_id_r];
        last_g_s = last_ext_s[grant_id_r];
        data_g_s = data_arr_s[grant_id_r];
        accept_s = (state_r == ST_SEND) & req_g_s & ~bus.i_fifo_full;
`ifdef ARB_HEADER_EN
        hdr_wr_s = (state_r == ST_HDR) & ~bus.i_fifo_full;
        if (state_r == ST_HDR) begin
            bus.o_fifo_write_word_data = {8'hA5, 8'h00, 8'h00, 5'b00000, grant_id_r};
        end else begin
            bus.o_fifo_write_word_data = data_g_s;
        end
`else
        hdr_wr_s = 1'b0;
        bus.o_fifo_write_word_data = data_g_s;
`endif
        bus.o_fifo_write_word_cmd = accept_s | hdr_wr_s;
        ack_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ack_s[k] = accept_s & (grant_id_r == 3'(k));
        end
        bus.o_ack = ack_s;
    end

    // Arbitration FSM with burst and stall counters; status outputs are registered here.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= 3'd0;
            grant_id_r  <= 3'd0;
            word_cnt_r  <= 8'd0;
            stall_cnt_r <= 16'd0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_id_r  <= sel_id_s;
                        word_cnt_r  <= 8'd0;
                        stall_cnt_r <= 16'd0;
                        busy_r      <= 1'b1;
`ifdef ARB_HEADER_EN
                        state_r     <= ST_HDR;
`else
                        state_r     <= ST_SEND;
`endif
                    end else begin
                        grant_id_r <= 3'd0;
                        busy_r     <= 1'b0;
                    end
                end
`ifdef ARB_HEADER_EN
                ST_HDR: begin
                    if (!bus.i_fifo_full) begin
                        state_r <= ST_SEND;
                    end else begin
                        state_r <= ST_HDR;
                    end
                end
`endif
                ST_SEND: begin
                    if (accept_s) begin
                        word_cnt_r  <= word_cnt_r + 8'd1;
                        stall_cnt_r <= 16'd0;
                        if (last_g_s || (word_cnt_r + 8'd1 == 8'(MAX_BURST))) begin
                            rr_ptr_r   <= next_idx(grant_id_r);
                            grant_id_r <= 3'd0;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            state_r <= ST_SEND;
                        end
                    end else if (!bus.i_fifo_full && !req_g_s) begin
                        // A full FIFO freezes the stall count; only a silent requester ages it.
                        stall_cnt_r <= stall_cnt_r + 16'd1;
                        if (stall_cnt_r + 16'd1 == 16'(TIMEOUT)) begin
                            timeout_r  <= 1'b1;
                            rr_ptr_r   <= next_idx(grant_id_r);
                            grant_id_r <= 3'd0;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            state_r <= ST_SEND;
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_id_r <= 3'd0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_grant_id = grant_id_r;
    assign bus.o_busy     = busy_r;
    assign bus.o_timeout  = timeout_r;

endmodule

// File: tb/tb_pc_tx_arbiter.sv
// Directed bench for pc_tx_arbiter (NUM_REQ=3, MAX_BURST=4, TIMEOUT=8).
// Build with ARB_HEADER_EN defined to exercise the header-word variant.
module tb_pc_tx_arbiter;
    localparam int NR = 3;
    localparam int MB = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_tx_arbiter_if #(.NUM_REQ(NR)) bus();

    pc_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] words [NR][16];
    logic        lastf [NR][16];
    int len [NR];
    int ptr [NR];
    int start [NR];
    int full_lo, full_hi;

    logic          cmd_log  [64];
    logic [31:0]   dat_log  [64];
    logic [NR-1:0] ack_log  [64];
    logic [2:0]    gnt_log  [64];
    logic          busy_log [64];
    logic          to_log   [64];
    logic [31:0]   wlog     [64];
    int            wsrc     [64];
    int            wcnt;

    task automatic clear_stim();
        for (int k = 0; k < NR; k++) begin
            len[k] = 0; ptr[k] = 0; start[k] = 0;
            for (int i = 0; i < 16; i++) begin
                words[k][i] = 32'h0;
                lastf[k][i] = 1'b0;
            end
        end
        full_lo = -1; full_hi = -2;
        bus.i_req = '0; bus.i_last = '0; bus.i_data = '0; bus.i_fifo_full = 1'b0;
    endtask

    task automatic do_reset();
        clear_stim();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive(input int c);
        int idx;
        for (int k = 0; k < NR; k++) begin
            idx = (ptr[k] < len[k]) ? ptr[k] : 0;
            bus.i_req[k]          = (c >= start[k]) && (ptr[k] < len[k]);
            bus.i_data[32*k +: 32] = words[k][idx];
            bus.i_last[k]         = lastf[k][idx];
        end
        bus.i_fifo_full = (c >= full_lo) && (c <= full_hi);
    endtask

    task automatic run(input int n);
        wcnt = 0;
        for (int c = 0; c < n; c++) begin
            drive(c);
            @(negedge clk);
            cmd_log[c]  = bus.o_fifo_write_word_cmd;
            dat_log[c]  = bus.o_fifo_write_word_data;
            ack_log[c]  = bus.o_ack;
            gnt_log[c]  = bus.o_grant_id;
            busy_log[c] = bus.o_busy;
            to_log[c]   = bus.o_timeout;
            if (bus.o_fifo_write_word_cmd) begin
                wlog[wcnt] = bus.o_fifo_write_word_data;
                wcnt++;
            end
            for (int k = 0; k < NR; k++) begin
                if (bus.o_ack[k]) ptr[k]++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        clear_stim();
        rst = 1'b1;
        bus.i_req = 3'b111;
        #2;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
        checks++; if (bus.o_fifo_write_word_cmd !== 1'b0) begin errors++; $display("FAIL rst_cmd: got %b want 0", bus.o_fifo_write_word_cmd); end
        checks++; if (bus.o_ack !== 3'b000) begin errors++; $display("FAIL rst_ack: got %b want 000", bus.o_ack); end
        checks++; if (bus.o_grant_id !== 3'd0 || bus.o_timeout !== 1'b0) begin errors++; $display("FAIL rst_gnt_to: got %0d/%b want 0/0", bus.o_grant_id, bus.o_timeout); end
        do_reset();
        len[0] = 3; words[0][0] = 32'hAAAA0001; words[0][1] = 32'hAAAA0002; words[0][2] = 32'hAAAA0003;
        lastf[0][2] = 1'b1;
        run(2);
        // Now in SEND with req0 still high: reset must kill the write immediately.
        rst = 1'b1;
        #1;
        checks++; if (bus.o_fifo_write_word_cmd !== 1'b0 || bus.o_ack !== 3'b000) begin errors++; $display("FAIL rst_mid_cmd: got cmd=%b ack=%b want 0/000", bus.o_fifo_write_word_cmd, bus.o_ack); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.o_busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_stim();
        run(4);
        checks++; if (wcnt !== 0) begin errors++; $display("FAIL rst_no_resume: got %0d writes want 0", wcnt); end
    endtask

    task automatic test_single();
        do_reset();
        len[0] = 3; words[0][0] = 32'h11111111; words[0][1] = 32'h22222222; words[0][2] = 32'h33333333;
        lastf[0][2] = 1'b1;
        run(6);
        checks++; if (cmd_log[0] !== 1'b0 || busy_log[0] !== 1'b0) begin errors++; $display("FAIL t1_idle_c0: got cmd=%b busy=%b want 0/0", cmd_log[0], busy_log[0]); end
        checks++; if (busy_log[1] !== 1'b1 || gnt_log[1] !== 3'd0) begin errors++; $display("FAIL t1_grant: got busy=%b gnt=%0d want 1/0", busy_log[1], gnt_log[1]); end
        for (int c = 1; c <= 3; c++) begin
            checks++; if (cmd_log[c] !== 1'b1 || ack_log[c] !== 3'b001 || dat_log[c] !== words[0][c-1]) begin
                errors++; $display("FAIL t1_word c%0d: got cmd=%b ack=%b data=%h want 1/001/%h", c, cmd_log[c], ack_log[c], dat_log[c], words[0][c-1]); end
        end
        checks++; if (cmd_log[4] !== 1'b0 || ack_log[4] !== 3'b000 || busy_log[4] !== 1'b0) begin errors++; $display("FAIL t1_end: got cmd=%b ack=%b busy=%b want 0/000/0", cmd_log[4], ack_log[4], busy_log[4]); end
        checks++; if (wcnt !== 3) begin errors++; $display("FAIL t1_count: got %0d want 3", wcnt); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_w [6];
        do_reset();
        for (int k = 0; k < NR; k++) begin
            len[k] = 2;
            words[k][0] = 32'hC0000000 + 32'(k * 16);
            words[k][1] = 32'hC0000001 + 32'(k * 16);
            lastf[k][1] = 1'b1;
            exp_w[2*k]   = words[k][0];
            exp_w[2*k+1] = words[k][1];
        end
        run(10);
        checks++; if (wcnt !== 6) begin errors++; $display("FAIL rr_count: got %0d want 6", wcnt); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (wlog[i] !== exp_w[i]) begin errors++; $display("FAIL rr_order w%0d: got %h want %h", i, wlog[i], exp_w[i]); end
        end
        checks++; if (gnt_log[1] !== 3'd0 || gnt_log[4] !== 3'd1 || gnt_log[7] !== 3'd2) begin
            errors++; $display("FAIL rr_grant_seq: got %0d,%0d,%0d want 0,1,2", gnt_log[1], gnt_log[4], gnt_log[7]); end
        checks++; if (cmd_log[3] !== 1'b0 || cmd_log[6] !== 1'b0 || busy_log[3] !== 1'b0 || busy_log[6] !== 1'b0) begin
            errors++; $display("FAIL rr_gap: got cmd %b%b busy %b%b want 00 00", cmd_log[3], cmd_log[6], busy_log[3], busy_log[6]); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        len[1] = 4;
        for (int i = 0; i < 4; i++) words[1][i] = 32'hF1F10000 + 32'(i);
        lastf[1][3] = 1'b1;
        full_lo = 2; full_hi = 5;
        run(11);
        checks++; if (gnt_log[1] !== 3'd1 || cmd_log[1] !== 1'b1) begin errors++; $display("FAIL full_first: got gnt=%0d cmd=%b want 1/1", gnt_log[1], cmd_log[1]); end
        for (int c = 2; c <= 5; c++) begin
            checks++; if (cmd_log[c] !== 1'b0 || ack_log[c] !== 3'b000) begin errors++; $display("FAIL full_hold c%0d: got cmd=%b ack=%b want 0/000", c, cmd_log[c], ack_log[c]); end
        end
        checks++; if (ack_log[6] !== 3'b010 || ack_log[7] !== 3'b010 || ack_log[8] !== 3'b010) begin errors++; $display("FAIL full_resume: got %b %b %b want 010", ack_log[6], ack_log[7], ack_log[8]); end
        checks++; if (wcnt !== 4) begin errors++; $display("FAIL full_count: got %0d want 4", wcnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wlog[i] !== words[1][i]) begin errors++; $display("FAIL full_order w%0d: got %h want %h", i, wlog[i], words[1][i]); end
        end
        checks++; if (busy_log[9] !== 1'b0) begin errors++; $display("FAIL full_idle: got %b want 0", busy_log[9]); end
    endtask

    task automatic test_max_burst();
        logic [31:0] exp_w [12];
        do_reset();
        len[0] = 10;
        for (int i = 0; i < 10; i++) words[0][i] = 32'hB0000000 + 32'(i + 1);
        lastf[0][9] = 1'b1;
        len[1] = 2; words[1][0] = 32'hB1000001; words[1][1] = 32'hB1000002; lastf[1][1] = 1'b1;
        for (int i = 0; i < 4; i++) exp_w[i] = words[0][i];
        exp_w[4] = words[1][0]; exp_w[5] = words[1][1];
        for (int i = 4; i < 10; i++) exp_w[i + 2] = words[0][i];
        run(18);
        checks++; if (wcnt !== 12) begin errors++; $display("FAIL mb_count: got %0d want 12", wcnt); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (wlog[i] !== exp_w[i]) begin errors++; $display("FAIL mb_order w%0d: got %h want %h", i, wlog[i], exp_w[i]); end
        end
        checks++; if (cmd_log[5] !== 1'b0 || gnt_log[6] !== 3'd1) begin errors++; $display("FAIL mb_switch: got cmd5=%b gnt6=%0d want 0/1", cmd_log[5], gnt_log[6]); end
    endtask

    task automatic test_timeout();
        do_reset();
        len[2] = 1; words[2][0] = 32'h22220001; lastf[2][0] = 1'b0;
        len[0] = 1; words[0][0] = 32'h00000F0F; lastf[0][0] = 1'b1; start[0] = 2;
        run(13);
        checks++; if (ack_log[1] !== 3'b100) begin errors++; $display("FAIL to_ack: got %b want 100", ack_log[1]); end
        for (int c = 0; c <= 9; c++) begin
            checks++; if (to_log[c] !== 1'b0) begin errors++; $display("FAIL to_early c%0d: got %b want 0", c, to_log[c]); end
        end
        checks++; if (to_log[10] !== 1'b1 || busy_log[10] !== 1'b0) begin errors++; $display("FAIL to_pulse: got to=%b busy=%b want 1/0", to_log[10], busy_log[10]); end
        checks++; if (to_log[11] !== 1'b0) begin errors++; $display("FAIL to_width: got %b want 0", to_log[11]); end
        checks++; if (busy_log[11] !== 1'b1 || gnt_log[11] !== 3'd0 || ack_log[11] !== 3'b001 || dat_log[11] !== 32'h00000F0F) begin
            errors++; $display("FAIL to_next: got busy=%b gnt=%0d ack=%b data=%h want 1/0/001/00000f0f", busy_log[11], gnt_log[11], ack_log[11], dat_log[11]); end
    endtask

    task automatic test_header();
        do_reset();
        len[1] = 1; words[1][0] = 32'hDEADBEEF; lastf[1][0] = 1'b1;
        run(5);
        checks++; if (wcnt !== 2) begin errors++; $display("FAIL hdr_count: got %0d want 2", wcnt); end
        checks++; if (cmd_log[1] !== 1'b1 || dat_log[1] !== 32'hA5000001 || ack_log[1] !== 3'b000) begin
            errors++; $display("FAIL hdr_word: got cmd=%b data=%h ack=%b want 1/a5000001/000", cmd_log[1], dat_log[1], ack_log[1]); end
        checks++; if (cmd_log[2] !== 1'b1 || dat_log[2] !== 32'hDEADBEEF || ack_log[2] !== 3'b010) begin
            errors++; $display("FAIL hdr_data: got cmd=%b data=%h ack=%b want 1/deadbeef/010", cmd_log[2], dat_log[2], ack_log[2]); end
        checks++; if (busy_log[3] !== 1'b0 || cmd_log[3] !== 1'b0) begin errors++; $display("FAIL hdr_end: got busy=%b cmd=%b want 0/0", busy_log[3], cmd_log[3]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
`ifdef ARB_HEADER_EN
        test_header();
`else
        test_single();
        test_round_robin();
        test_fifo_full();
        test_max_burst();
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
